// File: rtl/sipo_pkg.sv
// sipo_pkg
// Shared constants and helpers for the sipo_rx serial receiver.
//
// Configuration macro: SIPO_PARITY_EN
//   defined   -> each frame carries one even-parity bit after the n data bits
//   undefined -> frames are n data bits, no parity logic is built
//
// Contents:
//   PARITY_EN        1 when the parity bit is part of the frame
//   cnt_width(n)     width of the frame bit counter ($clog2(n+1))
//   frame_len(n)     qualified serial bits per frame (n, or n+1 with parity)
package sipo_pkg;

`ifdef SIPO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // The counter runs 0..frame_len-1, and frame_len is at most n+1,
  // so $clog2(n+1) bits always hold it.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int frame_len(input int n);
    return PARITY_EN ? (n + 1) : n;
  endfunction

endpackage

// File: rtl/sipo_bit_cnt.sv
// sipo_bit_cnt
// Frame bit counter for sipo_rx. Counts qualified serial bits within a frame,
// restarts at 1 when a frame-alignment bit is sampled, and wraps to 0 on the
// final bit of the frame.
//
// Configuration macro: SIPO_PARITY_EN (through sipo_pkg::frame_len)
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset
//   bit_valid in   a serial bit is sampled on this edge
//   start     in   the sampled bit is bit 0 of a new frame
//   last_bit  out  this edge samples the final bit of the frame (combinational)
//   busy      out  registered: a partial frame is in progress (count != 0)
module sipo_bit_cnt
  import sipo_pkg::*;
#(
  parameter int N = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_valid,
  input  logic start,
  output logic last_bit,
  output logic busy
);

  localparam int CW    = cnt_width(N);
  localparam int FRAME = frame_len(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  // A start bit is always bit 0, and a frame has at least two bits, so a
  // start bit can never be the last bit of a frame.
  always_comb begin
    last_bit   = 1'b0;
    count_next = count;
    if (bit_valid) begin
      if (start) begin
        count_next = ONE;
      end else if (count == LAST_IDX) begin
        count_next = '0;
        last_bit   = 1'b1;
      end else begin
        count_next = count + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      busy  <= 1'b0;
    end else begin
      count <= count_next;
      busy  <= (count_next != '0);
    end
  end

endmodule

// File: rtl/sipo_rx.sv
// sipo_rx
// Serial-in parallel-out receiver. Samples one serial bit per qualified clock,
// LSB first, assembles n-bit words and presents each on a valid/ready port
// backed by a single holding register. The serial side never stalls: a word
// that completes while the holding register is still occupied is dropped and
// the sticky overrun flag is raised.
//
// Configuration macro: SIPO_PARITY_EN
//   defined   -> frame is n data bits plus one even-parity bit; parity_err is
//                the XOR of all n+1 bits, registered with out_data
//   undefined -> frame is n bits; parity_err is constant 0
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   sin        in   serial data bit
//   sin_valid  in   qualifies sin
//   in_start   in   with sin_valid: this bit is bit 0 of a new word
//   out_data   out  [n-1:0] assembled word, bit 0 = first bit received
//   out_valid  out  out_data holds an unconsumed word
//   out_ready  in   consumer accepts the word
//   parity_err out  parity result for out_data, qualified by out_valid
//   overrun    out  sticky: a completed word was dropped
//   busy       out  a partial word is in progress
//
// Handshake: a word transfers on every rising edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0 the word and its
// parity flag are held stable. out_valid drops after a transfer unless a new
// word completes on that same edge, in which case the new word loads.
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         in_start,
  output logic [n-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         parity_err,
  output logic         overrun,
  output logic         busy
);

  logic [n-1:0] shift_reg;
  logic [n-1:0] word;
  logic         last_bit;
  logic         load;
  logic         drop;

  sipo_bit_cnt #(
    .N(n)
  ) u_bit_cnt (
    .clk      (clk),
    .reset    (reset),
    .bit_valid(sin_valid),
    .start    (in_start),
    .last_bit (last_bit),
    .busy     (busy)
  );

  // Right shift: the first bit received ends up in bit 0 after n shifts.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
    end else if (sin_valid) begin
      shift_reg <= {sin, shift_reg[n-1:1]};
    end
  end

`ifdef SIPO_PARITY_EN
  // The final bit is the parity bit, so the data is already fully shifted in.
  assign word = shift_reg;
`else
  // The final data bit is still on sin; merge it in as the word completes.
  assign word = {sin, shift_reg[n-1:1]};
`endif

  // The holding register can accept a completed word if it is empty or is
  // being emptied on this same edge.
  assign load = last_bit && (!out_valid || out_ready);
  assign drop = last_bit && out_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        out_data  <= word;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else if (load) begin
      parity_err <= ^{sin, shift_reg};
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
